// File: rtl/nip_window_assembler_pkg.sv
// rtl/nip_window_assembler_pkg.sv - default geometry, derived widths and FSM encoding for the window assembler
package nip_window_assembler_pkg;

  localparam int K_DEF         = 3;
  localparam int PW_DEF        = 8;
  localparam int IMG_W_DEF     = 16;
  localparam int IMG_H_DEF     = 16;
  localparam int OUT_DEPTH_DEF = 4;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int XW_DEF = width_of(IMG_W_DEF);
  localparam int YW_DEF = width_of(IMG_H_DEF);
  localparam int AW_DEF = width_of(OUT_DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/nip_window_assembler_if.sv
// rtl/nip_window_assembler_if.sv - column input stream and window output stream of the assembler
interface nip_window_assembler_if #(
  parameter int K  = 3,
  parameter int PW = 8,
  parameter int XW = 4,
  parameter int YW = 4
) ();

  logic                col_valid;
  logic [K*PW-1:0]     col_in;
  logic                win_valid;
  logic                win_ready;
  logic [K*K*PW-1:0]   win_out;
  logic [XW-1:0]       win_x;
  logic [YW-1:0]       win_y;

  modport master (
    output col_valid, col_in, win_ready,
    input  win_valid, win_out, win_x, win_y
  );

  modport slave (
    input  col_valid, col_in, win_ready,
    output win_valid, win_out, win_x, win_y
  );

endinterface

// File: rtl/nip_win_fifo.sv
// rtl/nip_win_fifo.sv - synchronous FIFO; a push into a full FIFO is taken when a pop happens in the same cycle
module nip_win_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/nip_window_assembler.sv
// rtl/nip_window_assembler.sv - builds KxK windows from a column stream, one band at a time.
// NIP_WIN_COORD_EN stores win_x/win_y with each buffered window; otherwise they read 0.
module nip_window_assembler
  import nip_window_assembler_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int PW        = PW_DEF,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  nip_window_assembler_if.slave    bus,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int XW = width_of(IMG_W);
  localparam int YW = width_of(IMG_H);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = K * PW;
  localparam int WW = K * K * PW;
`ifdef NIP_WIN_COORD_EN
  localparam int FW = WW + XW + YW;
`else
  localparam int FW = WW;
`endif

  state_e                state_q, state_d;
  logic [XW-1:0]         col_cnt_q, col_cnt_d;
  logic [YW-1:0]         band_cnt_q, band_cnt_d;
  logic [(K-1)*CW-1:0]   hist_q, hist_d;
  logic                  overflow_q, overflow_d;

  logic [WW-1:0]         window;
  logic [FW-1:0]         fifo_wdata, fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [AW:0]           fifo_count;
  logic                  push, pop, drop, col_step;
  logic                  col_last, band_last, fill_last, last_pop;

  // History holds column 0 in the low bits, so appending col_in yields the window layout directly.
  assign window    = {bus.col_in, hist_q};
  assign col_last  = (col_cnt_q == XW'(IMG_W - 1));
  assign band_last = (band_cnt_q == YW'(IMG_H - K));
  assign fill_last = (col_cnt_q == XW'(K - 2));
  assign pop       = !fifo_empty && bus.win_ready;
  assign last_pop  = pop && (fifo_count == (AW+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FILL:  if (bus.col_valid && fill_last) state_d = ST_RUN;
        ST_RUN:   if (bus.col_valid && col_last) state_d = band_last ? ST_DRAIN : ST_FILL;
        ST_DRAIN: if (fifo_empty || last_pop) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    col_step   = bus.col_valid && !frame_start && (state_q == ST_FILL || state_q == ST_RUN);
    push       = bus.col_valid && !frame_start && (state_q == ST_RUN);
    drop       = push && fifo_full && !pop;
    frame_done = (state_q == ST_DRAIN) && last_pop && !frame_start;
  end

  always_comb begin
    col_cnt_d  = col_cnt_q;
    band_cnt_d = band_cnt_q;
    hist_d     = hist_q;
    overflow_d = overflow_q;
    if (frame_start) begin
      col_cnt_d  = '0;
      band_cnt_d = '0;
      hist_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (col_step) begin
        hist_d = window[WW-1:CW];
        if (col_last) begin
          col_cnt_d  = '0;
          band_cnt_d = band_last ? '0 : band_cnt_q + YW'(1);
        end else begin
          col_cnt_d = col_cnt_q + XW'(1);
        end
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q  <= '0;
      band_cnt_q <= '0;
      hist_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_cnt_q  <= col_cnt_d;
      band_cnt_q <= band_cnt_d;
      hist_q     <= hist_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef NIP_WIN_COORD_EN
  assign fifo_wdata = {band_cnt_q, col_cnt_q, window};
  assign bus.win_x  = fifo_rdata[WW +: XW];
  assign bus.win_y  = fifo_rdata[WW+XW +: YW];
`else
  assign fifo_wdata = window;
  assign bus.win_x  = '0;
  assign bus.win_y  = '0;
`endif

  assign bus.win_valid = !fifo_empty;
  assign bus.win_out   = fifo_rdata[WW-1:0];
  assign overflow      = overflow_q;

  nip_win_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (frame_start),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
